mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multicycle control unit for the MIPS-subset core, replacing the single-cycle main decoder. It is a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles, and drives the shared-datapath multiplexers and write enables. It supports parametrised memory wait states, the full branch-variant set (beq/bne/bgt/bgte/ble/bleq), and flagging of illegal instructions. It sits between the instruction register and the multicycle datapath.

## Interface
Parameters:
- MEM_WAIT, 0 — extra wait cycles per memory access (0..15); each fetch/load/store holds for 1+MEM_WAIT cycles.
- WAIT_W, 4 — width of the internal wait counter; must hold MEM_WAIT.

Ports:
- clk  in  1  — single clock, rising edge.
- reset  in  1  — synchronous, active-high.
- instr  in  32  — instruction register contents; opcode = instr[31:26], funct = instr[5:0].
- pc_write  out  1  — PC load enable.
- ir_write  out  1  — instruction register load enable.
- i_or_d  out  1  — memory address select: 0 = PC, 1 = ALU result register.
- mem_read  out  1  — memory read strobe.
- mem_write  out  1  — memory write strobe.
- mem_to_reg  out  1  — register write data select: 1 = memory data register.
- reg_dst  out  1  — 1 = rd, 0 = rt.
- reg_write  out  1  — register file write enable.
- alu_src_a  out  1  — 0 = PC, 1 = rs.
- alu_src_b  out  2  — 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  — 00 = add, 01 = subtract/compare, 10 = decode by funct, 11 = decode by opcode (immediate logical/slt).
- pc_src  out  2  — 00 = ALU result, 01 = ALU-out register (branch target), 10 = jump target.
- branch  out  1  — branch-evaluate strobe; the datapath ANDs it with the condition selected by branch_type.
- branch_type  out  3  — 0 beq, 1 bne, 2 bgt, 3 bgte, 4 ble, 5 bleq.
- illegal  out  1  — one-cycle pulse on an unsupported instruction.
- state  out  4  — current state code, for debug only.

## Operation
- States (code): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE 6, ALUWB 7, IMMEX 8, IMMWB 9, BRANCH 10, JUMP 11, ILLEGAL 12.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. On the final wait cycle only: ir_write=1 and pc_write=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - lw 0x23 or sw 0x2B → MEMADR
  - 0x00 with funct 0x20/0x22/0x24/0x25/0x2A → RTYPE
  - 0x08/0x0C/0x0D/0x0A → IMMEX
  - 0x04/0x05/0x07/0x01/0x06/0x03 → BRANCH
  - 0x02 → JUMP
  - anything else (including an unsupported funct) → ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1, held for 1+MEM_WAIT cycles, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEMWR: mem_write=1, i_or_d=1, held for 1+MEM_WAIT cycles (asserted every cycle), then FETCH.
- RTYPE: alu_src_a=1, alu_src_b=00, alu_op=10, then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10, alu_op=11, then IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, branch_type decoded from opcode, then FETCH.
- JUMP: pc_src=10, pc_write=1, then FETCH.
- ILLEGAL: illegal=1, no write enables asserted, then FETCH. The instruction behaves as a nop; PC was already incremented in FETCH.
- Any output not listed for a state is 0.
- Wait counter: cleared on entry to FETCH, MEMRD and MEMWR; increments each held cycle; exit occurs when count == MEM_WAIT.

## Timing
- Outputs are decoded from the state register and wait counter only. No output depends combinationally on instr, except the DECODE next-state logic and branch_type in BRANCH.
- With W = MEM_WAIT, cycles per instruction are:
  - R-type and immediate: 4+W
  - lw: 5+2W
  - sw: 4+2W
  - branch and j: 3+W
  - illegal: 3+W
- Reset: while reset=1, state := FETCH and counter := 0 at each edge. The first cycle after deassertion is FETCH cycle 0.
- Reset asserted in any state, including mid-wait or mid-MEMWR, aborts the instruction. The same edge forces FETCH; no write enable is asserted in the following cycle except FETCH's final-cycle enables.
- Reset values (state FETCH, W>0): pc_write=0, ir_write=0, mem_write=0, reg_write=0, branch=0, illegal=0, mem_read=1, alu_src_b=01, all other outputs 0, state=0.
- With W=0, FETCH's first cycle is also its last, so ir_write=1 and pc_write=1 in that cycle.
- instr must be stable from DECODE until FETCH of the next instruction; ir_write only updates it on FETCH's last cycle.

## Test plan
- MEM_WAIT=0, add (opcode 0x00, funct 0x20) → states 0,1,6,7,0; reg_write=1 and reg_dst=1 in cycle 4 only; 4 cycles total.
- MEM_WAIT=2, lw (0x23) → FETCH held 3 cycles with ir_write on the 3rd; MEMRD held 3 cycles; MEMWB in cycle 9 with reg_write=1 and mem_to_reg=1.
- MEM_WAIT=1, sw (0x2B) → mem_write=1 for exactly 2 consecutive cycles; reg_write stays 0 throughout; 6 cycles total.
- Branches: each of opcodes 0x04, 0x05, 0x07, 0x01, 0x06, 0x03 → BRANCH with branch=1, pc_src=01, alu_op=01, and branch_type 0..5 respectively.
- Opcode 0x3F, and opcode 0x00 with funct 0x21 → ILLEGAL, illegal pulses for 1 cycle, no write enables, back to FETCH.
- MEM_WAIT=3: assert reset in the 2nd cycle of MEMWR → the next cycle is FETCH with mem_write=0 and counter=0; a subsequent j (0x02) shows pc_write=1 and pc_src=10 in JUMP.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/memory/write-back
// for the MIPS-subset shared datapath, with parametrised memory wait states.
module mc_ctrl_fsm #(
   parameter int MEM_WAIT = 0,
   parameter int WAIT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   output logic        pc_write,
   output logic        ir_write,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_src,
   output logic        branch,
   output logic [2:0]  branch_type,
   output logic        illegal,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPE   = 4'd6,
      S_ALUWB   = 4'd7,
      S_IMMEX   = 4'd8,
      S_IMMWB   = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BGT   = 6'h07;
   localparam logic [5:0] OP_BGTE  = 6'h01;
   localparam logic [5:0] OP_BLE   = 6'h06;
   localparam logic [5:0] OP_BLEQ  = 6'h03;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [WAIT_W-1:0] LP_WAIT = WAIT_W'(MEM_WAIT);

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_cnt;
   logic              w_last;
   logic [5:0]        w_opcode;
   logic [5:0]        w_funct;
   logic              w_funct_ok;

   assign w_opcode   = instr[31:26];
   assign w_funct    = instr[5:0];
   assign w_last     = (r_cnt == LP_WAIT);
   assign w_funct_ok = (w_funct == 6'h20) || (w_funct == 6'h22) || (w_funct == 6'h24) ||
                       (w_funct == 6'h25) || (w_funct == 6'h2A);
   assign state      = r_state;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         // Only the wait states ever hold; any state change clears the count.
         if (w_next != r_state) r_cnt <= '0;
         else                   r_cnt <= r_cnt + 1'b1;
      end
   end

   // NOTE: every output and w_next gets a default first so no path infers a latch.
   always_comb begin
      w_next      = r_state;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_to_reg  = 1'b0;
      reg_dst     = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      pc_src      = 2'b00;
      branch      = 1'b0;
      branch_type = 3'd0;
      illegal     = 1'b0;

      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (w_last) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               w_next   = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (w_opcode)
               OP_LW, OP_SW:                         w_next = S_MEMADR;
               OP_RTYPE:                             w_next = w_funct_ok ? S_RTYPE : S_ILLEGAL;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:    w_next = S_IMMEX;
               OP_BEQ, OP_BNE, OP_BGT, OP_BGTE,
               OP_BLE, OP_BLEQ:                      w_next = S_BRANCH;
               OP_J:                                 w_next = S_JUMP;
               default:                              w_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = (w_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (w_last) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (w_last) w_next = S_FETCH;
         end
         S_RTYPE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            w_next    = S_FETCH;
         end
         S_IMMEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            w_next    = S_IMMWB;
         end
         S_IMMWB: begin
            reg_write = 1'b1;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch    = 1'b1;
            case (w_opcode)
               OP_BEQ:  branch_type = 3'd0;
               OP_BNE:  branch_type = 3'd1;
               OP_BGT:  branch_type = 3'd2;
               OP_BGTE: branch_type = 3'd3;
               OP_BLE:  branch_type = 3'd4;
               OP_BLEQ: branch_type = 3'd5;
               default: branch_type = 3'd0;
            endcase
            w_next = S_FETCH;
         end
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            w_next   = S_FETCH;
         end
         S_ILLEGAL: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: four instances (MEM_WAIT 0..3) checked cycle by cycle
// against hand-built per-state output vectors.
module tb_mc_ctrl_fsm;

   localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3,
                          MW = 4'd4,  WR = 4'd5,  RT = 4'd6,  AW = 4'd7,
                          IX = 4'd8,  IW = 4'd9,  BR = 4'd10, JP = 4'd11,
                          IL = 4'd12;

   typedef struct {
      int          k;
      logic [23:0] v;
      string       tag;
   } sb_t;

   logic        clk = 1'b0;
   logic [3:0]  rst_v;
   logic [31:0] instr_v [4];
   wire  [23:0] w_o [4];

   sb_t sb_q[$];
   int  total = 0;
   int  bad   = 0;

   always #5 clk = ~clk;

   // Output vector layout: {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
   // reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], branch, branch_type[2:0],
   // illegal, state[3:0]}; instance g runs with MEM_WAIT = g.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      mc_ctrl_fsm #(.MEM_WAIT(g), .WAIT_W(4)) u_dut (
         .clk         (clk),
         .reset       (rst_v[g]),
         .instr       (instr_v[g]),
         .pc_write    (w_o[g][23]),
         .ir_write    (w_o[g][22]),
         .i_or_d      (w_o[g][21]),
         .mem_read    (w_o[g][20]),
         .mem_write   (w_o[g][19]),
         .mem_to_reg  (w_o[g][18]),
         .reg_dst     (w_o[g][17]),
         .reg_write   (w_o[g][16]),
         .alu_src_a   (w_o[g][15]),
         .alu_src_b   (w_o[g][14:13]),
         .alu_op      (w_o[g][12:11]),
         .pc_src      (w_o[g][10:9]),
         .branch      (w_o[g][8]),
         .branch_type (w_o[g][7:5]),
         .illegal     (w_o[g][4]),
         .state       (w_o[g][3:0])
      );
   end

   function automatic logic [23:0] ev(input logic [3:0] st, input bit last, input logic [2:0] bt);
      logic [23:0] v;
      v      = '0;
      v[3:0] = st;
      case (st)
         FE: begin v[20] = 1'b1; v[14:13] = 2'b01; if (last) begin v[23] = 1'b1; v[22] = 1'b1; end end
         DE: v[14:13] = 2'b11;
         MA: begin v[15] = 1'b1; v[14:13] = 2'b10; end
         MR: begin v[20] = 1'b1; v[21] = 1'b1; end
         MW: begin v[16] = 1'b1; v[18] = 1'b1; end
         WR: begin v[19] = 1'b1; v[21] = 1'b1; end
         RT: begin v[15] = 1'b1; v[12:11] = 2'b10; end
         AW: begin v[16] = 1'b1; v[17] = 1'b1; end
         IX: begin v[15] = 1'b1; v[14:13] = 2'b10; v[12:11] = 2'b11; end
         IW: v[16] = 1'b1;
         BR: begin v[15] = 1'b1; v[12:11] = 2'b01; v[10:9] = 2'b01; v[8] = 1'b1; v[7:5] = bt; end
         JP: begin v[10:9] = 2'b10; v[23] = 1'b1; end
         IL: v[4] = 1'b1;
         default: ;
      endcase
      return v;
   endfunction

   task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Monitor: one expected vector per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_t e;
         e = sb_q.pop_front();
         check(e.tag, w_o[e.k], e.v);
      end
   end

   task automatic push(input int k, input logic [3:0] st, input bit last, input logic [2:0] bt,
                       input string tag);
      sb_t e;
      e.k   = k;
      e.v   = ev(st, last, bt);
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic push_fetch(input int k, input string tag);
      for (int i = 0; i <= k; i++) push(k, FE, (i == k), 3'd0, $sformatf("%s_fetch%0d", tag, i));
   endtask

   // Returns on the posedge that closes the last expected cycle.
   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() > 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (sb_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Reset instance k with instr loaded, check the reset outputs, then release: the
   // cycle following return is FETCH cycle 0.
   task automatic begin_inst(input int k, input logic [31:0] ins, input string tag);
      @(posedge clk);
      #1;
      rst_v[k]   = 1'b1;
      instr_v[k] = ins;
      @(posedge clk);
      #1;
      push(k, FE, (k == 0), 3'd0, $sformatf("%s_rst", tag));
      drain();
      #1;
      rst_v[k] = 1'b0;
   endtask

   logic [5:0] bops [6];

   initial begin
      rst_v = 4'hF;
      for (int i = 0; i < 4; i++) instr_v[i] = '0;
      bops = '{6'h04, 6'h05, 6'h07, 6'h01, 6'h06, 6'h03};
      repeat (2) @(posedge clk);

      // add, W=0: 0,1,6,7,0
      begin_inst(0, {6'h00, 20'd0, 6'h20}, "add");
      push_fetch(0, "add");
      push(0, DE, 0, 3'd0, "add_dec");
      push(0, RT, 0, 3'd0, "add_rtype");
      push(0, AW, 0, 3'd0, "add_aluwb");
      push_fetch(0, "add_next");
      drain();

      // ori, W=0
      begin_inst(0, {6'h0D, 26'd0}, "ori");
      push_fetch(0, "ori");
      push(0, DE, 0, 3'd0, "ori_dec");
      push(0, IX, 0, 3'd0, "ori_immex");
      push(0, IW, 0, 3'd0, "ori_immwb");
      push_fetch(0, "ori_next");
      drain();

      // lw, W=2: 9 cycles
      begin_inst(2, {6'h23, 26'd0}, "lw");
      push_fetch(2, "lw");
      push(2, DE, 0, 3'd0, "lw_dec");
      push(2, MA, 0, 3'd0, "lw_memadr");
      for (int i = 0; i < 3; i++) push(2, MR, 0, 3'd0, $sformatf("lw_memrd%0d", i));
      push(2, MW, 0, 3'd0, "lw_memwb");
      push(2, FE, 0, 3'd0, "lw_next");
      drain();

      // sw, W=1: 6 cycles, mem_write on two
      begin_inst(1, {6'h2B, 26'd0}, "sw");
      push_fetch(1, "sw");
      push(1, DE, 0, 3'd0, "sw_dec");
      push(1, MA, 0, 3'd0, "sw_memadr");
      push(1, WR, 0, 3'd0, "sw_memwr0");
      push(1, WR, 0, 3'd0, "sw_memwr1");
      push(1, FE, 0, 3'd0, "sw_next");
      drain();

      // branch variants, W=0
      for (int i = 0; i < 6; i++) begin
         begin_inst(0, {bops[i], 26'd0}, $sformatf("br%0d", i));
         push_fetch(0, $sformatf("br%0d", i));
         push(0, DE, 0, 3'd0, $sformatf("br%0d_dec", i));
         push(0, BR, 0, 3'(i), $sformatf("br%0d_branch", i));
         push_fetch(0, $sformatf("br%0d_next", i));
         drain();
      end

      // illegal opcode and illegal funct, W=0
      begin_inst(0, {6'h3F, 26'd0}, "ill_op");
      push_fetch(0, "ill_op");
      push(0, DE, 0, 3'd0, "ill_op_dec");
      push(0, IL, 0, 3'd0, "ill_op_pulse");
      push_fetch(0, "ill_op_next");
      drain();

      begin_inst(0, {6'h00, 20'd0, 6'h21}, "ill_fn");
      push_fetch(0, "ill_fn");
      push(0, DE, 0, 3'd0, "ill_fn_dec");
      push(0, IL, 0, 3'd0, "ill_fn_pulse");
      push_fetch(0, "ill_fn_next");
      drain();

      // sw, W=3, reset during the 2nd MEMWR cycle, then a jump
      begin_inst(3, {6'h2B, 26'd0}, "rmw");
      push_fetch(3, "rmw");
      push(3, DE, 0, 3'd0, "rmw_dec");
      push(3, MA, 0, 3'd0, "rmw_memadr");
      push(3, WR, 0, 3'd0, "rmw_memwr0");
      drain();
      #1;
      rst_v[3]   = 1'b1;
      instr_v[3] = {6'h02, 26'd0};
      push(3, WR, 0, 3'd0, "rmw_memwr1");
      push(3, FE, 0, 3'd0, "rmw_abort_fetch");
      drain();
      #1;
      rst_v[3] = 1'b0;
      push_fetch(3, "j");
      push(3, DE, 0, 3'd0, "j_dec");
      push(3, JP, 0, 3'd0, "j_jump");
      push(3, FE, 0, 3'd0, "j_next");
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
